btn_bank: RTL and testbench
===========================

# btn_bank

Multi-channel successor to the single-button debouncer, used in the input front end between board push-buttons and game control logic. Each of `CHANNELS` asynchronous button inputs is synchronised, counter-debounced on a shared clock-enable tick, and turned into a stable level plus one-cycle press/release events. A long-press level (`btn_hold`) is added per channel. Optional auto-repeat re-fires press events while a button is held.

## Interface
- `CHANNELS`, 4: number of independent button channels (1..32).
- `COUNTER_WIDTH`, 16: debounce counter width; a level change must persist for 2^COUNTER_WIDTH `ce` ticks.
- `HOLD_WIDTH`, 8: width of the per-channel hold/repeat tick counter.
- `HOLD_TICKS`, 200: `ce` ticks of stable press before `btn_hold` asserts (1..2^HOLD_WIDTH-1).
- `REPEAT_TICKS`, 50: `ce` ticks between auto-repeat presses (1..2^HOLD_WIDTH-1).

- `clk`  in  1  system clock; all state on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ce`  in  1  debounce tick enable; counters advance only when high.
- `btn`  in  CHANNELS  raw asynchronous button levels, 1 = pressed.
- `btn_debounced`  out  CHANNELS  stable debounced level.
- `btn_press`  out  CHANNELS  one-`clk` pulse per press (and per repeat).
- `btn_release`  out  CHANNELS  one-`clk` pulse when debounced level falls.
- `btn_hold`  out  CHANNELS  high while pressed longer than `HOLD_TICKS`.

## Operation
- Per channel: 2-flop synchroniser clocked every `clk` (not gated by `ce`); output `s`.
- Debounce, on `ce` only: if `s == btn_debounced` then counter <= 0; else if counter == all-ones then `btn_debounced` <= `s`, counter <= 0; else counter <= counter + 1.
- `btn_press[i]` = 1 on the cycle after a ce-edge where `btn_debounced[i]` flips 0->1; `btn_release[i]` likewise for 1->0; both registered, otherwise 0.
- Hold state machine per channel: IDLE (debounced low) -> PRESSED on rise, hold counter cleared -> HELD when hold counter reaches `HOLD_TICKS` on a `ce` tick; any state -> IDLE on debounced fall (same edge as `btn_release`).
- Hold counter increments on `ce` in PRESSED; saturates; never wraps.
- `btn_hold` = 1 exactly in HELD.
- Channels fully independent; simultaneous events on several channels all reported in the same cycle.
- `ce` low: debounce, hold and repeat counters frozen; synchroniser keeps running.

## Timing
- Reset: all outputs 0, synchronisers 0, all counters 0, all channels IDLE. Reset mid-bounce or mid-hold discards progress; a button held through reset release produces a fresh press after full debounce.
- Latency with `ce` tied high: `btn` stable before edge k -> `btn_debounced` and `btn_press` high after edge k+1+2^COUNTER_WIDTH.
- Bounce shorter than 2^COUNTER_WIDTH consecutive ticks: no output change, no events.
- `btn_hold` rises on the edge the hold counter reaches `HOLD_TICKS`; falls together with `btn_release`.
- `btn_press` and `btn_release` never both high on one channel in one cycle.

## Configuration
- `BTN_BANK_REPEAT_EN` defined: in HELD, repeat counter counts `ce` ticks; on reaching `REPEAT_TICKS` it clears and `btn_press` pulses one cycle. First repeat comes `REPEAT_TICKS` ticks after `btn_hold` rises. Repeat counter cleared on entry to HELD and on release.
- Not defined: no repeat counter logic; exactly one `btn_press` per physical press.

## Structure
- `btn_bank_pkg`: hold-state enum (`IDLE`, `PRESSED`, `HELD`) and default parameter constants.
- Sub-module `btn_bank_channel`: synchroniser, debounce counter, hold FSM and optional repeat for one channel; top instantiates `CHANNELS` copies in a generate loop.

## Test plan
Bench: `COUNTER_WIDTH`=3, `HOLD_TICKS`=10, `REPEAT_TICKS`=4, `CHANNELS`=2, `ce`=1 unless noted.
- Reset asserted with `btn`=2'b11, released -> all outputs 0; `btn_debounced[1:0]`=11 and `btn_press`=11 for one cycle exactly 10 edges after first sample.
- Channel 0 toggles with random 1..7-cycle pulses -> no output change; then stable high -> one `btn_press[0]`, channel 1 silent.
- Stable press 30 cycles -> `btn_hold[0]` rises 10 ticks after `btn_press[0]`; release -> `btn_release[0]` and `btn_hold[0]` fall on same edge.
- With `BTN_BANK_REPEAT_EN`: hold press -> extra `btn_press[0]` pulses every 4 cycles after `btn_hold` rises; none without the macro.
- `ce` high 1 cycle in 4 -> debounce latency scales to 8 ce ticks; `ce` low freezes a partial count.
- `rst` pulsed mid-hold -> `btn_hold`, `btn_debounced` cleared immediately; new press reported after full debounce.

Source files
------------

// File: rtl/btn_bank_pkg.sv
// Shared types and default parameters for the btn_bank push-button front end.
// Auto-repeat is enabled by defining BTN_BANK_REPEAT_EN.
package btn_bank_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } hold_state_t;

    localparam int DEF_CHANNELS      = 4;
    localparam int DEF_COUNTER_WIDTH = 16;
    localparam int DEF_HOLD_WIDTH    = 8;
    localparam int DEF_HOLD_TICKS    = 200;
    localparam int DEF_REPEAT_TICKS  = 50;

endpackage

// File: rtl/btn_bank_channel.sv
// One button channel: synchroniser, counter debounce, long-press FSM and,
// when BTN_BANK_REPEAT_EN is defined, auto-repeat of press events while held.
module btn_bank_channel
    import btn_bank_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int HOLD_WIDTH    = DEF_HOLD_WIDTH,
    parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
    parameter int REPEAT_TICKS  = DEF_REPEAT_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic raw,
    output logic level,
    output logic press,
    output logic fall,
    output logic hold
);

    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX    = '1;
    localparam logic [HOLD_WIDTH-1:0] HOLD_TARGET = HOLD_WIDTH'(HOLD_TICKS);

    if (HOLD_TICKS < 1 || HOLD_TICKS > (2 ** HOLD_WIDTH) - 1) begin : g_bad_hold
        $error("btn_bank_channel: HOLD_TICKS out of range");
    end
    if (REPEAT_TICKS < 1 || REPEAT_TICKS > (2 ** HOLD_WIDTH) - 1) begin : g_bad_repeat
        $error("btn_bank_channel: REPEAT_TICKS out of range");
    end

    logic                     sync1_reg;
    logic                     sync2_reg;
    logic                     level_reg;
    logic [COUNTER_WIDTH-1:0] db_cnt_reg;
    logic                     press_reg;
    logic                     fall_reg;
    hold_state_t              state_reg;
    hold_state_t              state_next;
    logic [HOLD_WIDTH-1:0]    hold_cnt_reg;
    logic [HOLD_WIDTH-1:0]    hold_cnt_next;
    logic [HOLD_WIDTH-1:0]    hold_cnt_inc;
    logic                     flip;
    logic                     rise;
    logic                     fall_ev;
    logic                     rep_fire;

    // The debounced level only changes after the counter has run through all
    // 2^COUNTER_WIDTH ticks of a persistent difference.
    assign flip    = ce && (sync2_reg != level_reg) && (db_cnt_reg == '1);
    assign rise    = flip && sync2_reg;
    assign fall_ev = flip && !sync2_reg;

    assign hold_cnt_inc = (hold_cnt_reg == HOLD_MAX) ? hold_cnt_reg
                                                     : hold_cnt_reg + HOLD_WIDTH'(1);

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (rise) begin
                    state_next    = PRESSED;
                    hold_cnt_next = '0;
                end
            end
            PRESSED: begin
                if (fall_ev) begin
                    state_next = IDLE;
                end else if (ce) begin
                    hold_cnt_next = hold_cnt_inc;
                    if (hold_cnt_inc == HOLD_TARGET) begin
                        state_next = HELD;
                    end
                end
            end
            HELD: begin
                if (fall_ev) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef BTN_BANK_REPEAT_EN
    localparam logic [HOLD_WIDTH-1:0] REPEAT_TARGET = HOLD_WIDTH'(REPEAT_TICKS);

    logic [HOLD_WIDTH-1:0] rep_cnt_reg;
    logic [HOLD_WIDTH-1:0] rep_cnt_next;
    logic [HOLD_WIDTH-1:0] rep_cnt_inc;

    assign rep_cnt_inc = rep_cnt_reg + HOLD_WIDTH'(1);

    // Counting only while staying in HELD clears it on entry and on release,
    // and a release tick can never also fire a repeat.
    always_comb begin
        rep_cnt_next = rep_cnt_reg;
        rep_fire     = 1'b0;
        if (state_reg != HELD || state_next != HELD) begin
            rep_cnt_next = '0;
        end else if (ce) begin
            if (rep_cnt_inc == REPEAT_TARGET) begin
                rep_fire     = 1'b1;
                rep_cnt_next = '0;
            end else begin
                rep_cnt_next = rep_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_reg <= '0;
        end else begin
            rep_cnt_reg <= rep_cnt_next;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            level_reg    <= 1'b0;
            db_cnt_reg   <= '0;
            press_reg    <= 1'b0;
            fall_reg     <= 1'b0;
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (ce) begin
                if (sync2_reg == level_reg) begin
                    db_cnt_reg <= '0;
                end else if (db_cnt_reg == '1) begin
                    level_reg  <= sync2_reg;
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + COUNTER_WIDTH'(1);
                end
            end
            press_reg    <= rise || rep_fire;
            fall_reg     <= fall_ev;
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign level = level_reg;
    assign press = press_reg;
    assign fall  = fall_reg;
    assign hold  = (state_reg == HELD);

endmodule

// File: rtl/btn_bank.sv
// Bank of independent debounced push-button channels with press/release
// events and long-press level; BTN_BANK_REPEAT_EN adds auto-repeat.
module btn_bank
    import btn_bank_pkg::*;
#(
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int HOLD_WIDTH    = DEF_HOLD_WIDTH,
    parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
    parameter int REPEAT_TICKS  = DEF_REPEAT_TICKS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] btn_debounced,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_hold
);

    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
        $error("btn_bank: CHANNELS out of range");
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        btn_bank_channel #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .HOLD_WIDTH    (HOLD_WIDTH),
            .HOLD_TICKS    (HOLD_TICKS),
            .REPEAT_TICKS  (REPEAT_TICKS)
        ) u_channel (
            .clk   (clk),
            .rst   (rst),
            .ce    (ce),
            .raw   (btn[gi]),
            .level (btn_debounced[gi]),
            .press (btn_press[gi]),
            .fall  (btn_release[gi]),
            .hold  (btn_hold[gi])
        );
    end

endmodule

// File: tb/tb_btn_bank.sv
// Scoreboard bench for btn_bank: expected output-change events are queued with
// their cycle numbers and a monitor compares every observed output change.
module tb_btn_bank;

    localparam int CH = 2;

    logic          clk;
    logic          rst;
    logic          ce;
    logic [CH-1:0] btn;
    logic [CH-1:0] btn_debounced;
    logic [CH-1:0] btn_press;
    logic [CH-1:0] btn_release;
    logic [CH-1:0] btn_hold;

    btn_bank #(
        .CHANNELS      (CH),
        .COUNTER_WIDTH (3),
        .HOLD_WIDTH    (8),
        .HOLD_TICKS    (10),
        .REPEAT_TICKS  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .btn           (btn),
        .btn_debounced (btn_debounced),
        .btn_press     (btn_press),
        .btn_release   (btn_release),
        .btn_hold      (btn_hold)
    );

    typedef struct {
        int       at;
        logic [7:0] val;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc;
    int         n_cmp;
    int         n_fail;
    int         mode;       // 0: ce high, 1: ce one edge in four, 2: ce low
    logic [7:0] outv;
    logic [7:0] prev_outv;

    assign outv = {btn_hold, btn_release, btn_press, btn_debounced};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mk(logic [1:0] deb, logic [1:0] prs,
                                      logic [1:0] rel, logic [1:0] hld);
        return {hld, rel, prs, deb};
    endfunction

    task automatic push(int at, logic [7:0] val);
        ev_t e;
        e.at  = at;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // One press episode: press pulse, optional hold (and repeats), then either
    // a release pulse or an abrupt clear by reset at fall_at.
    task automatic expect_episode(logic [1:0] m, int p, int h, int f, bit by_rst);
        push(p, mk(m, m, 2'b00, 2'b00));
        push(p + 1, mk(m, 2'b00, 2'b00, 2'b00));
        if (h != 0) begin
            push(h, mk(m, 2'b00, 2'b00, m));
`ifdef BTN_BANK_REPEAT_EN
            for (int t = h + 4; t + 1 < f; t += 4) begin
                push(t, mk(m, m, 2'b00, m));
                push(t + 1, mk(m, 2'b00, 2'b00, m));
            end
`endif
        end
        if (by_rst) begin
            push(f, 8'h00);
        end else begin
            push(f, mk(2'b00, 2'b00, m, 2'b00));
            push(f + 1, 8'h00);
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ce = (mode == 1) ? ((cyc % 4) == 3) : (mode == 0);
        end
    endtask

    task automatic chk(string name, logic [7:0] got, logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %b expected %b", name, cyc, got, want);
        end else begin
            $display("ok   %s: cycle %0d outputs %b", name, cyc, got);
        end
    endtask

    task automatic monitor_loop();
        ev_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL missing_event: expected %b at cycle %0d, not seen by cycle %0d",
                         exp_q[0].val, exp_q[0].at, cyc);
                void'(exp_q.pop_front());
            end
            if (outv !== prev_outv) begin
                n_cmp++;
                if (exp_q.size() == 0 || exp_q[0].at != cyc) begin
                    n_fail++;
                    $display("FAIL unexpected_event: cycle %0d got %b, next expected at %0d",
                             cyc, outv, (exp_q.size() > 0) ? exp_q[0].at : -1);
                end else begin
                    e = exp_q.pop_front();
                    if (e.val !== outv) begin
                        n_fail++;
                        $display("FAIL event_value: cycle %0d got %b expected %b", cyc, outv, e.val);
                    end else begin
                        $display("ok   event: cycle %0d outputs %b", cyc, outv);
                    end
                end
            end
            prev_outv = outv;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int r;
        cyc       = 0;
        n_cmp     = 0;
        n_fail    = 0;
        mode      = 0;
        prev_outv = 8'h00;
        rst       = 1'b1;
        ce        = 1'b1;
        btn       = 2'b11;
        fork
            monitor_loop();
        join_none

        // Reset held with both buttons pressed, then a fresh press after debounce.
        run(1);
        chk("reset_outputs", outv, 8'h00);
        run(1);
        chk("reset_outputs_hold", outv, 8'h00);
        r   = cyc;
        rst = 1'b0;
        expect_episode(2'b11, r + 10, r + 20, r + 35, 1'b0);
        run(25);
        btn = 2'b00;
        run(15);

        // Bounce on channel 0 stays silent; a stable press is then reported once.
        for (int i = 0; i < 6; i++) begin
            btn[0] = 1'b1;
            run(int'($urandom_range(7, 1)));
            btn[0] = 1'b0;
            run(int'($urandom_range(7, 1)));
        end
        run(3);
        c = cyc;
        btn[0] = 1'b1;
        expect_episode(2'b01, c + 10, c + 20, c + 40, 1'b0);
        run(30);
        btn[0] = 1'b0;
        run(15);

        // ce low for 10 edges mid-count on channel 1 delays the press by 10.
        c = cyc;
        btn[1] = 1'b1;
        expect_episode(2'b10, c + 20, c + 30, c + 42, 1'b0);
        run(5);
        mode = 2;
        run(10);
        mode = 0;
        run(17);
        btn[1] = 1'b0;
        run(15);

        // ce one edge in four: debounce takes 8 ce ticks, released before hold.
        mode = 1;
        run(8);
        while ((cyc % 4) != 1) run(1);
        c = cyc;
        btn[0] = 1'b1;
        expect_episode(2'b01, c + 31, 0, c + 67, 1'b0);
        run(36);
        btn[0] = 1'b0;
        run(40);
        mode = 0;
        run(4);

        // Reset mid-hold clears at once; the still-held button re-debounces.
        c = cyc;
        btn[0] = 1'b1;
        expect_episode(2'b01, c + 10, c + 20, c + 26, 1'b1);
        run(25);
        #2 rst = 1'b1;
        #1 chk("async_reset_clear", outv, 8'h00);
        run(2);
        r   = cyc;
        rst = 1'b0;
        expect_episode(2'b01, r + 10, r + 20, r + 31, 1'b0);
        run(21);
        btn[0] = 1'b0;
        run(20);

        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
